pipe_bk_adder: RTL and testbench

PIPE_BK_ADDER -- requirements
Module: pipe_bk_adder

---
 rtl/pipe_bk_adder.sv | 186 ++++++++++++++++++
 tb/tb_pipe_bk_adder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_bk_adder.sv
// rtl/pipe_bk_adder.sv - Pipelined Brent-Kung add/sub with valid/ready flow control; optional out_ovf under PIPE_BK_ADDER_OVF_EN
module pipe_bk_adder #(
    parameter int WIDTH  = 12,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_bits,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef PIPE_BK_ADDER_OVF_EN
    output logic               out_ovf,
`endif
    output logic [WIDTH:0]     out_sum
);

    // Prefix tree is built over the operand width padded to a power of two.
    localparam int LG = $clog2(WIDTH);
    localparam int N  = 1 << LG;
    // LG up-sweep levels followed by LG-1 down-sweep levels.
    localparam int T  = 2 * LG - 1;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Up-sweep level t pairs with distance 2^t; down-sweep levels shrink back towards 1.
    function automatic int lvl_dist(input int t);
        return (t < LG) ? (1 << t) : (1 << (2 * LG - 2 - t));
    endfunction

    // Bit positions that receive a group combine at prefix level t.
    function automatic logic [N-1:0] lvl_mask(input int t);
        logic [N-1:0] m;
        int           d;
        m = '0;
        d = lvl_dist(t);
        for (int i = 0; i < N; i++) begin
            if (t < LG) begin
                if (((i + 1) % (2 * d)) == 0)
                    m = m | (ONE << i);
            end else begin
                if ((((i + 1) % (2 * d)) == d) && (i >= 2 * d))
                    m = m | (ONE << i);
            end
        end
        return m;
    endfunction

    // First prefix level handled by pipeline segment s; levels are spread evenly.
    function automatic int seg_lo(input int s);
        return (s * T) / STAGES;
    endfunction

    // Group generate after applying prefix levels [lo, hi).
    function automatic logic [N-1:0] seg_g(input int lo, input int hi,
                                           input logic [N-1:0] g_in, input logic [N-1:0] p_in);
        logic [N-1:0] g;
        logic [N-1:0] p;
        logic [N-1:0] m;
        int           d;
        g = g_in;
        p = p_in;
        for (int t = lo; t < hi; t++) begin
            m = lvl_mask(t);
            d = lvl_dist(t);
            g = g | (m & p & (g << d));
            p = p & (~m | (p << d));
        end
        return g;
    endfunction

    // Group propagate after applying prefix levels [lo, hi).
    function automatic logic [N-1:0] seg_p(input int lo, input int hi, input logic [N-1:0] p_in);
        logic [N-1:0] p;
        logic [N-1:0] m;
        p = p_in;
        for (int t = lo; t < hi; t++) begin
            m = lvl_mask(t);
            p = p & (~m | (p << lvl_dist(t)));
        end
        return p;
    endfunction

    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [WIDTH-1:0] be_w;
    logic [WIDTH-1:0] x_in;
    logic [N-1:0]     g_in;
    logic [N-1:0]     p_in;

    logic [N-1:0]     g_d [STAGES];
    logic [N-1:0]     p_d [STAGES];
    logic [WIDTH-1:0] x_d [STAGES];
    logic [STAGES-1:0] cin_d;

    logic [N-1:0]     g_q [STAGES];
    logic [N-1:0]     p_q [STAGES];
    logic [WIDTH-1:0] x_q [STAGES];
    logic [STAGES-1:0] cin_q;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              go;
    logic [WIDTH-1:0]  carries;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_split
            assign a_w[gi] = in_bits[2*gi];
            assign b_w[gi] = in_bits[2*gi+1];
        end
    endgenerate

    // Bit-level generate/propagate; the subtract carry-in is folded into bit 0's generate.
    always_comb begin
        be_w           = b_w ^ {WIDTH{in_sub}};
        x_in           = a_w ^ be_w;
        g_in           = '0;
        p_in           = '0;
        g_in[WIDTH-1:0] = a_w & be_w;
        g_in[0]        = (a_w[0] & be_w[0]) | (x_in[0] & in_sub);
        p_in[WIDTH-1:0] = x_in;
    end

    // Each segment applies its share of prefix levels to the previous stage's registers.
    always_comb begin
        g_d[0]   = seg_g(seg_lo(0), seg_lo(1), g_in, p_in);
        p_d[0]   = seg_p(seg_lo(0), seg_lo(1), p_in);
        x_d[0]   = x_in;
        cin_d    = '0;
        cin_d[0] = in_sub;
        for (int s = 1; s < STAGES; s++) begin
            g_d[s]   = seg_g(seg_lo(s), seg_lo(s + 1), g_q[s-1], p_q[s-1]);
            p_d[s]   = seg_p(seg_lo(s), seg_lo(s + 1), p_q[s-1]);
            x_d[s]   = x_q[s-1];
            cin_d[s] = cin_q[s-1];
        end
    end

    // Backpressure walks from the output towards the input: a stage moves when its successor can take it.
    always_comb begin
        go  = out_ready;
        adv = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s] = valid_q[s] & go;
            go     = ~valid_q[s] | adv[s];
        end
        in_ready = ~rst & go;
        load     = (adv << 1) | STAGES'(in_valid & in_ready);
        valid_d  = load | (valid_q & ~adv);
    end

    // Stage occupancy; reset empties the pipe and drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= '0;
        else
            valid_q <= valid_d;
    end

    // Stage data registers capture only when their stage is loaded, so a stalled stage holds.
    always_ff @(posedge clk) begin
        for (int s = 0; s < STAGES; s++) begin
            if (load[s]) begin
                g_q[s]   <= g_d[s];
                p_q[s]   <= p_d[s];
                x_q[s]   <= x_d[s];
                cin_q[s] <= cin_d[s];
            end
        end
    end

    // Final sum XOR uses the completed carries of the last stage; output reads 0 when not valid.
    assign carries   = {g_q[STAGES-1][WIDTH-2:0], cin_q[STAGES-1]};
    assign out_valid = valid_q[STAGES-1] & ~rst;
    assign out_sum   = out_valid ? {g_q[STAGES-1][WIDTH-1], x_q[STAGES-1] ^ carries} : '0;

`ifdef PIPE_BK_ADDER_OVF_EN
    // Signed overflow is the carry into the MSB differing from the carry out of it.
    assign out_ovf = out_valid & (g_q[STAGES-1][WIDTH-1] ^ g_q[STAGES-1][WIDTH-2]);
`endif

endmodule

// File: tb/tb_pipe_bk_adder.sv
// tb/tb_pipe_bk_adder.sv - Randomized and directed self-checking bench for pipe_bk_adder
module tb_pipe_bk_adder;

    localparam int W = 12;
    localparam int S = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] in_bits;
    logic           in_sub;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     out_sum;
`ifdef PIPE_BK_ADDER_OVF_EN
    logic           out_ovf;
`endif

    pipe_bk_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_BK_ADDER_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_sum   (out_sum)
    );

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
        int         cyc;
        int         stalls;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk;
    int         n_fail;
    int         cyc;
    int         stall_cnt;
    int         n_xfer;
    int         run_len;
    int         max_run;
    bit         prev_stall;
    logic [W:0] prev_sum;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    // Reference: plain integer arithmetic on the de-interleaved operands.
    function automatic exp_t model(input logic [2*W-1:0] bits, input logic sub, input int c, input int st);
        exp_t   e;
        longint ua, ub, ia, ib, r, lim;
        ua = 0;
        ub = 0;
        for (int i = 0; i < W; i++) begin
            if (bits[2*i])   ua = ua + (longint'(1) << i);
            if (bits[2*i+1]) ub = ub + (longint'(1) << i);
        end
        lim = longint'(1) << (W - 1);
        if (sub) e.sum = (W+1)'(ua + ((longint'(1) << W) - 1 - ub) + 1);
        else     e.sum = (W+1)'(ua + ub);
        ia = (ua >= lim) ? ua - 2 * lim : ua;
        ib = (ub >= lim) ? ub - 2 * lim : ub;
        r  = sub ? ia - ib : ia + ib;
        e.ovf    = (r > lim - 1) || (r < -lim);
        e.cyc    = c;
        e.stalls = st;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (out_valid) run_len++;
        else           run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (rst) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (out_valid && out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", out_sum, e.sum);
                    if (e.stalls == stall_cnt) chk("latency", cyc - e.cyc, S);
`ifdef PIPE_BK_ADDER_OVF_EN
                    chk("ovf", out_ovf, e.ovf);
`endif
                end
            end
            if (out_valid && !out_ready) begin
                if (prev_stall) chk("hold_sum", out_sum, prev_sum);
                stall_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            if (in_valid && in_ready) exp_q.push_back(model(in_bits, in_sub, cyc, stall_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                           input logic [W:0] exp_sum, input string tag, output logic ovf_seen);
        bit acc;
        bit seen;
        int lat;
        in_bits   = pack(a, b);
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        acc       = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_acc"}, acc, 1);
        seen = 0;
        lat  = 0;
        ovf_seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        chk({tag, "_lat"}, lat, S);
        chk({tag, "_sum"}, out_sum, exp_sum);
`ifdef PIPE_BK_ADDER_OVF_EN
        ovf_seen = out_ovf;
`endif
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         acc;
        int         x0;
        logic       ovf;
        logic [W-1:0] ra, rb;
        n_chk = 0; n_fail = 0; cyc = 0; stall_cnt = 0; n_xfer = 0;
        run_len = 0; max_run = 0; prev_stall = 0; prev_sum = '0;
        rst = 1'b1; in_valid = 1'b0; in_bits = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_sum", out_sum, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_sum", out_sum, 0);
        step();

        run_one(12'hFFF, 12'h001, 1'b0, 13'h1000, "add_wrap", ovf);
        run_one(12'h005, 12'h003, 1'b1, 13'h1002, "sub_pos", ovf);
        run_one(12'h003, 12'h005, 1'b1, 13'h0FFE, "sub_neg", ovf);
        run_one(12'h000, 12'h000, 1'b1, 13'h1000, "sub_zero", ovf);
`ifdef PIPE_BK_ADDER_OVF_EN
        run_one(12'h7FF, 12'h001, 1'b0, 13'h0800, "ovf_add", ovf);
        chk("ovf_add_flag", ovf, 1);
        run_one(12'h800, 12'h001, 1'b1, 13'h17FF, "ovf_sub", ovf);
        chk("ovf_sub_flag", ovf, 1);
        run_one(12'h001, 12'h001, 1'b0, 13'h0002, "ovf_none", ovf);
        chk("ovf_none_flag", ovf, 0);
`endif

        // Eight back-to-back adds with the output always ready.
        max_run = 0;
        x0 = n_xfer;
        out_ready = 1'b1;
        in_sub = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            in_bits = pack(ra, rb);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_xfers", n_xfer - x0, 8);
        chk("stream_run", max_run, 8);

        // Stall with input pressure: pipe fills to S entries then refuses.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_bits = W'($urandom) == 0 ? '0 : pack(W'($urandom), W'($urandom));
            in_sub  = 1'($urandom);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        chk("stall_accepted", acc, S);
        @(negedge clk);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        step();
        x0 = n_xfer;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_bits = pack(W'($urandom), W'($urandom));
            in_sub  = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("release_xfers", n_xfer - x0, S + 10);

        // Reset with two results in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sub    = 1'b0;
        in_bits   = pack(12'h123, 12'h456);
        step();
        in_bits   = pack(12'h0AA, 12'h055);
        step();
        in_valid  = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_out_valid", out_valid, 0);
        chk("after_rst_in_ready", in_ready, 1);
        x0 = n_xfer;
        out_ready = 1'b1;
        repeat (6) step();
        chk("no_stale_xfers", n_xfer - x0, 0);

        // Random traffic with random backpressure and biased operands.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: ra = '0;
                1: ra = '1;
                default: ra = W'($urandom);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
            in_bits   = pack(ra, rb);
            in_sub    = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        chk("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
